// File: rtl/hilo_unit.sv
// hilo_unit: EX-stage HI/LO unit with 1-cycle mt*/mf*/mult/mul and a radix-2 restoring divider; DIV_ZERO_FAST_EN short-circuits divide by zero
module hilo_unit #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic        flush,
  input  logic [8:0]  hilo_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stallreq,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [5:0] LAST = 6'(DIV_ITERS - 1);
  state_t state;
  logic [31:0] hi, lo, dvd, dvs, rem, mag_a, mag_b, q_fix, r_fix;
  logic [5:0] count;
  logic sign_q, sign_r, is_div, commit, start, fast_zero, ge;
  logic [63:0] sprod, uprod;
  logic [32:0] trial, diff;
  assign is_div = hilo_op[2] | hilo_op[1];
  assign commit = ex_valid & ~ex_stall & ~flush;
  assign sprod = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign uprod = {32'b0, src_a} * {32'b0, src_b};
`ifdef DIV_ZERO_FAST_EN
  assign fast_zero = src_b == 32'b0;
`else
  assign fast_zero = 1'b0;
`endif
  assign start = state == IDLE & ex_valid & is_div & ~flush & ~fast_zero;
  assign stallreq = start | state == BUSY;
  assign mag_a = (hilo_op[2] & src_a[31]) ? -src_a : src_a;
  assign mag_b = (hilo_op[2] & src_b[31]) ? -src_b : src_b;
  assign trial = {rem, dvd[31]};
  assign diff = trial - {1'b0, dvs};
  assign ge = ~diff[32];
  assign q_fix = sign_q ? -dvd : dvd;
  assign r_fix = sign_r ? -rem : rem;
  assign hilo_rdata = hilo_op[8] ? hi : hilo_op[7] ? lo : hilo_op[0] ? sprod[31:0] : 32'b0;
  assign hi_o = hi;
  assign lo_o = lo;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hi <= '0;
      lo <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      count <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dvd <= mag_a;
          dvs <= mag_b;
          rem <= '0;
          count <= '0;
          sign_q <= hilo_op[2] & (src_a[31] ^ src_b[31]);
          sign_r <= hilo_op[2] & src_a[31];
          state <= BUSY;
        end
        BUSY: begin
          rem <= ge ? diff[31:0] : trial[31:0];
          dvd <= {dvd[30:0], ge};
          count <= count + 6'd1;
          if (count == LAST) state <= DONE;
        end
        DONE: if (commit) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit) begin
        if (hilo_op[6]) hi <= src_a;
        if (hilo_op[5]) lo <= src_a;
        if (hilo_op[4]) {hi, lo} <= sprod;
        if (hilo_op[3]) {hi, lo} <= uprod;
        if (state == DONE & is_div) {hi, lo} <= {r_fix, q_fix};
        if (state == IDLE & is_div & fast_zero) {hi, lo} <= {src_a, 32'hFFFF_FFFF};
      end
    end
  end
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed literal checks plus randomized pipeline traffic against a behavioural HI/LO model
module tb_hilo_unit;
  logic clk = 0, rst = 1, ex_valid = 0, ex_stall = 0, flush = 0;
  logic [8:0] hilo_op = '0;
  logic [31:0] src_a = '0, src_b = '0;
  logic stallreq;
  logic [31:0] hilo_rdata, hi_o, lo_o;
  localparam logic [8:0] MFHI = 9'h100, MFLO = 9'h080, MTHI = 9'h040, MTLO = 9'h020,
    MULT = 9'h010, MULTU = 9'h008, DIV = 9'h004, DIVU = 9'h002, MUL = 9'h001;
  int checks = 0, fails = 0;
  int n = -1;
  logic [31:0] m_hi = '0, m_lo = '0, m_q = '0, m_r = '0;
  logic leave = 1;
  hilo_unit dut (.clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall), .flush(flush),
    .hilo_op(hilo_op), .src_a(src_a), .src_b(src_b), .stallreq(stallreq),
    .hilo_rdata(hilo_rdata), .hi_o(hi_o), .lo_o(lo_o));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  // Model: n counts edges since a divide issued; stall spans the issue cycle plus 32 more
  always @(negedge clk) begin
    logic isdiv, fz, cm, issue, e_st;
    logic [31:0] e_rd;
    longint sa, sb;
    longint unsigned up;
    isdiv = hilo_op[2] | hilo_op[1];
`ifdef DIV_ZERO_FAST_EN
    fz = src_b == 0;
`else
    fz = 0;
`endif
    cm = ex_valid & ~ex_stall & ~flush;
    issue = n < 0 && ex_valid && isdiv && !flush && !fz;
    e_st = issue || (n >= 1 && n <= 32);
    sa = longint'($signed(src_a));
    sb = longint'($signed(src_b));
    e_rd = hilo_op[8] ? m_hi : hilo_op[7] ? m_lo : hilo_op[0] ? 32'(sa * sb) : 32'h0;
    chk("stallreq", {31'b0, stallreq}, {31'b0, e_st});
    chk("hilo_rdata", hilo_rdata, e_rd);
    chk("hi_o", hi_o, m_hi);
    chk("lo_o", lo_o, m_lo);
    leave = flush | ~ex_valid | (~ex_stall & ~e_st);
    if (rst) begin
      n = -1; m_hi = 0; m_lo = 0;
    end else if (flush) n = -1;
    else if (n < 0) begin
      if (issue) begin
        n = 1;
        if (hilo_op[1]) begin sa = longint'({32'b0, src_a}); sb = longint'({32'b0, src_b}); end
        if (sb == 0) begin
          m_q = (hilo_op[2] && src_a[31]) ? 32'h1 : 32'hFFFF_FFFF;
          m_r = src_a;
        end else begin
          m_q = 32'(sa / sb);
          m_r = 32'(sa % sb);
        end
      end else if (cm) begin
        up = 64'({32'b0, src_a}) * 64'({32'b0, src_b});
        if (hilo_op[6]) m_hi = src_a;
        if (hilo_op[5]) m_lo = src_a;
        if (hilo_op[4]) {m_hi, m_lo} = 64'(longint'($signed(src_a)) * longint'($signed(src_b)));
        if (hilo_op[3]) {m_hi, m_lo} = up;
        if (isdiv && fz) begin m_hi = src_a; m_lo = 32'hFFFF_FFFF; end
      end
    end else if (n < 33) n++;
    else if (cm) begin
      m_hi = m_r; m_lo = m_q; n = -1;
    end
  end
  task automatic idle();
    hilo_op = '0; ex_valid = 0; ex_stall = 0; flush = 0;
  endtask
  task automatic run(input logic [8:0] op, input logic [31:0] a, input logic [31:0] b, output int st);
    bit ok = 0;
    hilo_op = op; src_a = a; src_b = b; ex_valid = 1; ex_stall = 0; flush = 0; st = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!stallreq) begin ok = 1; break; end
      st++;
      @(posedge clk);
    end
    if (!ok) chk("run_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 idle();
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int st, k;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_hi", hi_o, 0); chk("rst_lo", lo_o, 0); chk("rst_stall", {31'b0, stallreq}, 0);
    run(MTHI, 32'h1234, 0, st);
    run(MTLO, 32'hABCD, 0, st);
    hilo_op = MFHI; ex_valid = 1;
    #1 chk("mfhi", hilo_rdata, 32'h1234);
    hilo_op = MFLO;
    #1 chk("mflo", hilo_rdata, 32'hABCD);
    idle();
    run(MULT, 32'hFFFF_FFFE, 3, st);
    chk("mult_hi", hi_o, 32'hFFFF_FFFF); chk("mult_lo", lo_o, 32'hFFFF_FFFA);
    run(MULTU, 32'hFFFF_FFFE, 3, st);
    chk("multu_hi", hi_o, 32'h2); chk("multu_lo", lo_o, 32'hFFFF_FFFA);
    hilo_op = MUL; src_a = 32'hFFFF_FFFE; src_b = 3;
    #1 chk("mul_rdata", hilo_rdata, 32'hFFFF_FFFA);
    run(MUL, 32'hFFFF_FFFE, 3, st);
    chk("mul_hi", hi_o, 32'h2); chk("mul_lo", lo_o, 32'hFFFF_FFFA);
    run(DIV, -32'sd7, 2, st);
    chk("div_stalls", st, 33); chk("div_lo", lo_o, 32'hFFFF_FFFD); chk("div_hi", hi_o, 32'hFFFF_FFFF);
    run(DIVU, 100, 7, st);
    chk("divu_lo", lo_o, 14); chk("divu_hi", hi_o, 2);
    run(DIV, 32'h8000_0000, 32'hFFFF_FFFF, st);
    chk("ovf_lo", lo_o, 32'h8000_0000); chk("ovf_hi", hi_o, 0);
    hilo_op = DIV; src_a = -32'sd7; src_b = 2; ex_valid = 1;
    repeat (33) @(posedge clk);
    #1 ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("done_hold_stall", {31'b0, stallreq}, 0);
      @(posedge clk);
    end
    #1 chk("done_hold_hi", hi_o, 0);
    ex_stall = 0;
    @(posedge clk);
    #1 idle();
    chk("done_hi", hi_o, 32'hFFFF_FFFF); chk("done_lo", lo_o, 32'hFFFF_FFFD);
    @(posedge clk);
    #1 chk("no_restart", {31'b0, stallreq}, 0);
    hilo_op = DIVU; src_a = 100; src_b = 7; ex_valid = 1;
    repeat (11) @(posedge clk);
    #1 flush = 1;
    chk("busy_stall", {31'b0, stallreq}, 1);
    @(posedge clk);
    #1 idle();
    chk("flush_stall", {31'b0, stallreq}, 0);
    chk("flush_hi", hi_o, 32'hFFFF_FFFF); chk("flush_lo", lo_o, 32'hFFFF_FFFD);
    run(DIVU, 5, 0, st);
`ifdef DIV_ZERO_FAST_EN
    chk("dz_stalls", st, 0);
`else
    chk("dz_stalls", st, 33);
`endif
    chk("dz_hi", hi_o, 5); chk("dz_lo", lo_o, 32'hFFFF_FFFF);
    hilo_op = DIV; src_a = 9; src_b = 2; ex_valid = 1;
    repeat (5) @(posedge clk);
    #1 rst = 1; idle();
    @(posedge clk);
    #1 rst = 0;
    chk("mid_rst_hi", hi_o, 0); chk("mid_rst_lo", lo_o, 0); chk("mid_rst_stall", {31'b0, stallreq}, 0);
    for (int c = 0; c < 5000; c++) begin
      if (leave) begin
        k = $urandom_range(0, 11);
        hilo_op = k < 9 ? 9'(1 << k) : k == 9 ? 9'h0 : k == 10 ? DIV : DIVU;
        src_a = pick(); src_b = pick();
        ex_valid = $urandom_range(0, 7) != 0;
      end
      ex_stall = $urandom_range(0, 5) == 0;
      flush = $urandom_range(0, 39) == 0;
      @(posedge clk);
      #1;
    end
    idle();
    @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
